// File: rtl/mm2s_rd_arbiter_pkg.sv
// Shared definitions for the mm2s read-channel arbiter and its helpers:
// FSM state encoding and the default channel widths.
package mm2s_pkg;

    localparam int unsigned DEFAULT_AXI_ADDR_WIDTH = 42;
    localparam int unsigned DEFAULT_AXI_ID_WIDTH   = 2;
    localparam int unsigned DEFAULT_RX_SIZE_WIDTH  = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mm2s_rd_arbiter_if.sv
// Bundle of the loader-side and mm2s-side signals of the read arbiter.
// Signal names are from the arbiter's point of view; "master" is the
// arbiter, "slave" is everything around it (loaders plus AXI read master).
interface mm2s_rd_arbiter_if
    import mm2s_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int unsigned AXI_ID_WIDTH   = DEFAULT_AXI_ID_WIDTH,
    parameter int unsigned RX_SIZE_WIDTH  = DEFAULT_RX_SIZE_WIDTH,
    parameter int unsigned NUM_REQ        = 4
);
    logic [NUM_REQ-1:0]                i_req_addr_req;
    logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] i_req_addr;
    logic [NUM_REQ*RX_SIZE_WIDTH-1:0]  i_req_size;
    logic [NUM_REQ-1:0]                o_req_addr_ack;
    logic [NUM_REQ-1:0]                o_req_data_req;
    logic [NUM_REQ-1:0]                i_req_data_ready;
    logic [NUM_REQ-1:0]                o_req_done;
    logic [AXI_ID_WIDTH-1:0]           o_mm2s_req_id;
    logic [RX_SIZE_WIDTH-1:0]          o_mm2s_size;
    logic [AXI_ADDR_WIDTH-1:0]         o_mm2s_addr;
    logic                              o_mm2s_addr_req;
    logic                              i_mm2s_addr_ready;
    logic [AXI_ID_WIDTH-1:0]           i_mm2s_get_id;
    logic                              i_mm2s_data_req;
    logic                              o_mm2s_data_ready;
    logic                              i_mm2s_done;
    logic                              o_busy;
    logic                              o_short_err;
    logic                              o_wdog_err;

    modport master (
        input  i_req_addr_req, i_req_addr, i_req_size, i_req_data_ready,
        input  i_mm2s_addr_ready, i_mm2s_get_id, i_mm2s_data_req, i_mm2s_done,
        output o_req_addr_ack, o_req_data_req, o_req_done,
        output o_mm2s_req_id, o_mm2s_size, o_mm2s_addr, o_mm2s_addr_req,
        output o_mm2s_data_ready, o_busy, o_short_err, o_wdog_err
    );

    modport slave (
        output i_req_addr_req, i_req_addr, i_req_size, i_req_data_ready,
        output i_mm2s_addr_ready, i_mm2s_get_id, i_mm2s_data_req, i_mm2s_done,
        input  o_req_addr_ack, o_req_data_req, o_req_done,
        input  o_mm2s_req_id, o_mm2s_size, o_mm2s_addr, o_mm2s_addr_req,
        input  o_mm2s_data_ready, o_busy, o_short_err, o_wdog_err
    );

endinterface

// File: rtl/mm2s_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// scanning upward from last+1 with wrap at NUM_REQ. Shared with the
// s2mm-side arbiter.
module rr_pick #(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    // Scan farthest candidate first so the nearest set bit after 'last' wins.
    always_comb begin
        int unsigned pos;
        pos   = 0;
        valid = |req;
        idx   = '0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            pos = (32'(last) + i) % NUM_REQ;
            if (req[IDX_W'(pos)]) begin
                idx = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mm2s_rd_arbiter.sv
// Round-robin arbiter sharing the single mm2s read channel between NUM_REQ
// load controllers. Grants one requester per burst, steers its data beats,
// and re-arbitrates on the rising edge of the channel's done level.
// Optional build macro MM2S_RD_ARB_WDOG_EN adds a data-phase stall watchdog.
module mm2s_rd_arbiter
    import mm2s_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int unsigned AXI_ID_WIDTH   = DEFAULT_AXI_ID_WIDTH,
    parameter int unsigned RX_SIZE_WIDTH  = DEFAULT_RX_SIZE_WIDTH,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned WDOG_CYCLES    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    mm2s_rd_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [RX_SIZE_WIDTH-1:0] CNT_MAX = '1;

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          grant_q;
    logic [IDX_W-1:0]          last_grant_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [RX_SIZE_WIDTH-1:0]  size_q;
    logic [RX_SIZE_WIDTH-1:0]  beat_cnt_q, beat_cnt_nx;
    logic                      done_q;
    logic                      short_err_q;

    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_idx;
    logic [AXI_ADDR_WIDTH-1:0] sel_addr;
    logic [RX_SIZE_WIDTH-1:0]  sel_size;

    logic [NUM_REQ-1:0]        grant_onehot;
    logic                      id_match, data_ready, beat, done_rise, wdog_hit;
    logic                      latch, clr_cnt, finish, set_short, wdog_fire, addr_req;
    logic [NUM_REQ-1:0]        ack_vec, data_req_vec, done_vec;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.i_req_addr_req),
        .last  (last_grant_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Select the winning requester's address and size from the packed buses.
    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                sel_addr = bus.i_req_addr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                sel_size = bus.i_req_size[k*RX_SIZE_WIDTH +: RX_SIZE_WIDTH];
            end
        end
    end

    assign grant_onehot = NUM_REQ'(1) << grant_q;
    assign id_match     = (bus.i_mm2s_get_id == AXI_ID_WIDTH'(grant_q));
    assign data_ready   = (state_q == S_DATA) && bus.i_req_data_ready[grant_q] && id_match;
    assign beat         = data_ready && bus.i_mm2s_data_req;
    assign done_rise    = bus.i_mm2s_done && !done_q;
    assign beat_cnt_nx  = (beat && beat_cnt_q != CNT_MAX) ? beat_cnt_q + RX_SIZE_WIDTH'(1)
                                                          : beat_cnt_q;

`ifdef MM2S_RD_ARB_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;

    // Hit on the WDOG_CYCLES-th consecutive data-phase cycle without a beat.
    assign wdog_hit = (state_q == S_DATA) && !beat && (wdog_q == WD_W'(WDOG_CYCLES - 1));

    // Count beat-less data-phase cycles; restart on every beat and on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else if (clr_cnt || beat || state_q != S_DATA) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WD_W'(1);
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    // Next-state and per-cycle strobes of the grant FSM.
    always_comb begin
        state_d      = state_q;
        latch        = 1'b0;
        clr_cnt      = 1'b0;
        finish       = 1'b0;
        set_short    = 1'b0;
        wdog_fire    = 1'b0;
        addr_req     = 1'b0;
        ack_vec      = '0;
        data_req_vec = '0;
        done_vec     = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    latch   = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                addr_req = 1'b1;
                if (bus.i_mm2s_addr_ready) begin
                    ack_vec = grant_onehot;
                    clr_cnt = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.i_mm2s_data_req && id_match) begin
                    data_req_vec = grant_onehot;
                end
                if (done_rise) begin
                    done_vec  = grant_onehot;
                    finish    = 1'b1;
                    set_short = (beat_cnt_nx < size_q);
                    state_d   = S_IDLE;
                end else if (wdog_hit) begin
                    done_vec  = grant_onehot;
                    finish    = 1'b1;
                    wdog_fire = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant latches, beat counter, done-edge history and sticky short flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            addr_q       <= '0;
            size_q       <= '0;
            beat_cnt_q   <= '0;
            done_q       <= 1'b1;
            short_err_q  <= 1'b0;
        end else begin
            done_q <= bus.i_mm2s_done;
            if (latch) begin
                grant_q <= pick_idx;
                addr_q  <= sel_addr;
                size_q  <= sel_size;
            end
            if (clr_cnt) begin
                beat_cnt_q <= '0;
            end else if (state_q == S_DATA) begin
                beat_cnt_q <= beat_cnt_nx;
            end
            if (finish) begin
                last_grant_q <= grant_q;
            end
            if (set_short) begin
                short_err_q <= 1'b1;
            end
        end
    end

    assign bus.o_req_addr_ack    = ack_vec;
    assign bus.o_req_data_req    = data_req_vec;
    assign bus.o_req_done        = done_vec;
    assign bus.o_mm2s_req_id     = AXI_ID_WIDTH'(grant_q);
    assign bus.o_mm2s_size       = size_q;
    assign bus.o_mm2s_addr       = addr_q;
    assign bus.o_mm2s_addr_req   = addr_req;
    assign bus.o_mm2s_data_ready = data_ready;
    assign bus.o_busy            = (state_q != S_IDLE);
    assign bus.o_short_err       = short_err_q;
    assign bus.o_wdog_err        = wdog_fire;

endmodule

// File: tb/tb_mm2s_rd_arbiter.sv
// Self-checking bench for mm2s_rd_arbiter: randomized bursts checked against
// a round-robin reference model kept here. Honours MM2S_RD_ARB_WDOG_EN.
module tb_mm2s_rd_arbiter;

    localparam int unsigned AW = 42;
    localparam int unsigned IW = 2;
    localparam int unsigned SW = 10;
    localparam int unsigned N  = 4;
    localparam int unsigned WD = 16;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   m_last;
    logic [AW-1:0] m_addr [N];
    logic [SW-1:0] m_size [N];

    typedef struct {
        int          gid;
        logic [AW-1:0] addr;
        logic [SW-1:0] size;
        logic [N-1:0]  ack;
        logic [N-1:0]  ack2;
        logic [N-1:0]  done1;
        logic [N-1:0]  done2;
        logic        busy_after;
        logic        short_after;
        int          own_seen;
        int          ready_bad;
        int          strobe_bad;
        bit          timeout;
    } obs_t;

    mm2s_rd_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW),
                         .RX_SIZE_WIDTH(SW), .NUM_REQ(N)) bus ();

    mm2s_rd_arbiter #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_ID_WIDTH   (IW),
        .RX_SIZE_WIDTH  (SW),
        .NUM_REQ        (N),
        .WDOG_CYCLES    (WD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference arbitration rule: first requester after the last grant, wrapping.
    function automatic int model_pick(input logic [N-1:0] mask, input int last);
        for (int s = 1; s <= int'(N); s++) begin
            if (mask[(last + s) % N]) return (last + s) % N;
        end
        return -1;
    endfunction

    task automatic apply_reqs();
        for (int k = 0; k < int'(N); k++) begin
            bus.i_req_addr[k*AW +: AW] = m_addr[k];
            bus.i_req_size[k*SW +: SW] = m_size[k];
        end
    endtask

    task automatic drive_idle();
        bus.i_req_addr_req    = '0;
        bus.i_req_data_ready  = '0;
        bus.i_mm2s_addr_ready = 1'b0;
        bus.i_mm2s_get_id     = '0;
        bus.i_mm2s_data_req   = 1'b0;
        bus.i_mm2s_done       = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_last = N - 1;
    endtask

    // Plays loader + AXI master for one burst and records what the DUT showed.
    task automatic do_burst(input logic [N-1:0] mask, input bit hold, input int lat,
                            input int own, input int foreign, output obs_t o);
        int cyc, own_left, for_left, fid, id;
        logic dreq, exp_rdy;
        logic [N-1:0] rdy, exp_strb;
        o = '{default: 0};
        @(negedge clk);
        bus.i_req_addr_req = mask;
        cyc = 0;
        while (bus.o_mm2s_addr_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) begin
            o.timeout = 1'b1;
            bus.i_req_addr_req = '0;
            return;
        end
        o.gid  = int'(bus.o_mm2s_req_id);
        o.addr = bus.o_mm2s_addr;
        o.size = bus.o_mm2s_size;
        repeat (lat) @(negedge clk);
        bus.i_mm2s_addr_ready = 1'b1;
        #1 o.ack = bus.o_req_addr_ack;
        @(negedge clk);
        bus.i_mm2s_addr_ready = 1'b0;
        if (!hold) bus.i_req_addr_req = '0;
        #1 o.ack2 = bus.o_req_addr_ack;
        own_left = own;
        for_left = foreign;
        fid      = (o.gid + 1) % N;
        cyc      = 0;
        while ((own_left > 0 || for_left > 0) && cyc < 5000) begin
            cyc++;
            dreq = ($urandom % 4) != 0;
            id   = (for_left > 0 && (own_left == 0 || $urandom % 3 == 0)) ? fid : o.gid;
            rdy  = N'($urandom);
            if ($urandom % 4 != 0) rdy[o.gid] = 1'b1;
            bus.i_mm2s_data_req  = dreq;
            bus.i_mm2s_get_id    = IW'(id);
            bus.i_req_data_ready = rdy;
            #1;
            exp_rdy  = (id == o.gid) && rdy[o.gid];
            exp_strb = (dreq && id == o.gid) ? (N'(1) << o.gid) : '0;
            if (bus.o_mm2s_data_ready !== exp_rdy) o.ready_bad++;
            if (bus.o_req_data_req !== exp_strb) o.strobe_bad++;
            if (dreq && bus.o_req_data_req[o.gid] === 1'b1 && bus.o_mm2s_data_ready === 1'b1)
                o.own_seen++;
            if (dreq && exp_rdy) own_left--;
            else if (dreq && id != o.gid) for_left--;
            @(negedge clk);
        end
        if (cyc >= 5000) o.timeout = 1'b1;
        bus.i_mm2s_data_req = 1'b0;
        bus.i_mm2s_done     = 1'b1;
        #1 o.done1 = bus.o_req_done;
        @(negedge clk);
        #1;
        o.done2       = bus.o_req_done;
        o.busy_after  = bus.o_busy;
        o.short_after = bus.o_short_err;
        bus.i_mm2s_done = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.o_busy, bus.o_mm2s_addr_req, bus.o_mm2s_data_ready,
             bus.o_short_err, bus.o_wdog_err} !== 5'b0) begin
            $display("FAIL reset_flags: got %b want 00000", {bus.o_busy, bus.o_mm2s_addr_req,
                     bus.o_mm2s_data_ready, bus.o_short_err, bus.o_wdog_err});
            n_bad++;
        end
        n_cmp++;
        if ({bus.o_req_addr_ack, bus.o_req_data_req, bus.o_req_done} !== '0) begin
            $display("FAIL reset_strobes: got %h want 0",
                     {bus.o_req_addr_ack, bus.o_req_data_req, bus.o_req_done});
            n_bad++;
        end
        n_cmp++;
        if ({bus.o_mm2s_req_id, bus.o_mm2s_addr, bus.o_mm2s_size} !== '0) begin
            $display("FAIL reset_bus: got id=%0h addr=%0h size=%0h want 0",
                     bus.o_mm2s_req_id, bus.o_mm2s_addr, bus.o_mm2s_size);
            n_bad++;
        end
    endtask

    task automatic test_single();
        obs_t o;
        int exp;
        m_addr[1] = AW'(64'h1000);
        m_size[1] = SW'(256);
        apply_reqs();
        exp = model_pick(4'b0010, m_last);
        do_burst(4'b0010, 1'b0, 3, 256, 0, o);
        n_cmp++;
        if (o.timeout || o.gid != exp) begin
            $display("FAIL single_grant: got id=%0d timeout=%0d want id=%0d", o.gid, o.timeout, exp);
            n_bad++;
        end
        n_cmp++;
        if (o.addr !== m_addr[1] || o.size !== m_size[1]) begin
            $display("FAIL single_addr: got %0h/%0d want %0h/%0d", o.addr, o.size, m_addr[1], m_size[1]);
            n_bad++;
        end
        n_cmp++;
        if (o.ack !== 4'b0010 || o.ack2 !== 4'b0000) begin
            $display("FAIL single_ack: got %b then %b want 0010 then 0000", o.ack, o.ack2);
            n_bad++;
        end
        n_cmp++;
        if (o.own_seen != 256 || o.ready_bad != 0 || o.strobe_bad != 0) begin
            $display("FAIL single_beats: got beats=%0d rdy_err=%0d strb_err=%0d want 256/0/0",
                     o.own_seen, o.ready_bad, o.strobe_bad);
            n_bad++;
        end
        n_cmp++;
        if (o.done1 !== 4'b0010 || o.done2 !== 4'b0000 || o.busy_after !== 1'b0) begin
            $display("FAIL single_done: got %b then %b busy=%b want 0010 then 0000 busy=0",
                     o.done1, o.done2, o.busy_after);
            n_bad++;
        end
        n_cmp++;
        if (o.short_after !== 1'b0) begin
            $display("FAIL single_short: got %b want 0", o.short_after);
            n_bad++;
        end
        m_last = exp;
    endtask

    task automatic test_foreign_id();
        obs_t o;
        int exp;
        m_addr[1] = AW'(64'h2000);
        m_size[1] = SW'(4);
        apply_reqs();
        exp = model_pick(4'b0010, m_last);
        do_burst(4'b0010, 1'b0, 1, 3, 4, o);
        n_cmp++;
        if (o.timeout || o.gid != exp) begin
            $display("FAIL foreign_grant: got id=%0d timeout=%0d want id=%0d", o.gid, o.timeout, exp);
            n_bad++;
        end
        n_cmp++;
        if (o.ready_bad != 0 || o.strobe_bad != 0) begin
            $display("FAIL foreign_steer: got rdy_err=%0d strb_err=%0d want 0/0", o.ready_bad, o.strobe_bad);
            n_bad++;
        end
        n_cmp++;
        if (o.short_after !== 1'b1) begin
            $display("FAIL foreign_count: got short=%b want 1 (3 of 4 own beats)", o.short_after);
            n_bad++;
        end
        m_last = exp;
    endtask

    task automatic test_short();
        obs_t o;
        int exp;
        do_reset();
        n_cmp++;
        if (bus.o_short_err !== 1'b0) begin
            $display("FAIL short_cleared: got %b want 0", bus.o_short_err);
            n_bad++;
        end
        m_addr[2] = AW'(64'h3000);
        m_size[2] = SW'(256);
        apply_reqs();
        exp = model_pick(4'b0100, m_last);
        do_burst(4'b0100, 1'b0, 2, 200, 0, o);
        n_cmp++;
        if (o.timeout || o.gid != exp || o.done1 !== 4'b0100 || o.short_after !== 1'b1) begin
            $display("FAIL short_set: got id=%0d done=%b short=%b want id=%0d done=0100 short=1",
                     o.gid, o.done1, o.short_after, exp);
            n_bad++;
        end
        m_last = exp;
        exp = model_pick(4'b0100, m_last);
        do_burst(4'b0100, 1'b0, 0, 256, 0, o);
        n_cmp++;
        if (o.timeout || o.short_after !== 1'b1) begin
            $display("FAIL short_sticky: got short=%b timeout=%0d want 1", o.short_after, o.timeout);
            n_bad++;
        end
        m_last = exp;
    endtask

    task automatic test_reset_mid_data();
        obs_t o;
        int cyc;
        logic [N-1:0] seen_done;
        m_size[3] = SW'(16);
        apply_reqs();
        @(negedge clk);
        bus.i_req_addr_req = 4'b1000;
        cyc = 0;
        while (bus.o_mm2s_addr_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        bus.i_mm2s_addr_ready = 1'b1;
        @(negedge clk);
        bus.i_mm2s_addr_ready = 1'b0;
        bus.i_req_addr_req    = '0;
        bus.i_mm2s_get_id     = IW'(3);
        bus.i_mm2s_data_req   = 1'b1;
        bus.i_req_data_ready  = '1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b1 || bus.o_mm2s_data_ready !== 1'b1) begin
            $display("FAIL midrst_pre: got busy=%b ready=%b want 1/1", bus.o_busy, bus.o_mm2s_data_ready);
            n_bad++;
        end
        #2 reset = 1'b1;
        bus.i_mm2s_done = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_busy, bus.o_mm2s_addr_req, bus.o_mm2s_data_ready, bus.o_short_err,
             bus.o_req_data_req, bus.o_req_done, bus.o_mm2s_req_id, bus.o_mm2s_addr} !== '0) begin
            $display("FAIL midrst_async: got busy=%b ready=%b short=%b dreq=%b id=%0h addr=%0h want all 0",
                     bus.o_busy, bus.o_mm2s_data_ready, bus.o_short_err, bus.o_req_data_req,
                     bus.o_mm2s_req_id, bus.o_mm2s_addr);
            n_bad++;
        end
        bus.i_mm2s_data_req  = 1'b0;
        bus.i_req_data_ready = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_last = N - 1;
        seen_done = '0;
        repeat (6) begin
            @(negedge clk);
            #1 seen_done |= bus.o_req_done;
        end
        n_cmp++;
        if (seen_done !== '0) begin
            $display("FAIL midrst_done_held: got done=%b want 0000", seen_done);
            n_bad++;
        end
        bus.i_mm2s_done = 1'b0;
        do_burst(4'b1111, 1'b0, 1, 16, 0, o);
        n_cmp++;
        if (o.timeout || o.gid != model_pick(4'b1111, m_last) || o.gid != 0) begin
            $display("FAIL midrst_next_grant: got id=%0d timeout=%0d want 0", o.gid, o.timeout);
            n_bad++;
        end
        m_last = o.gid;
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp;
        do_reset();
        for (int k = 0; k < int'(N); k++) begin
            m_addr[k] = AW'({$urandom, $urandom});
            m_size[k] = SW'($urandom_range(1, 4));
        end
        apply_reqs();
        for (int b = 0; b < 8; b++) begin
            exp = model_pick(4'b1111, m_last);
            do_burst(4'b1111, 1'b1, $urandom_range(0, 3), int'(m_size[exp]), 0, o);
            n_cmp++;
            if (o.timeout || o.gid != exp || o.gid != b % int'(N)) begin
                $display("FAIL rr_order[%0d]: got id=%0d timeout=%0d want %0d", b, o.gid, o.timeout, b % N);
                n_bad++;
            end
            n_cmp++;
            if (o.addr !== m_addr[exp] || o.size !== m_size[exp] || o.done1 !== (N'(1) << exp)
                || o.busy_after !== 1'b0 || o.short_after !== 1'b0) begin
                $display("FAIL rr_burst[%0d]: got addr=%0h size=%0d done=%b busy=%b short=%b want addr=%0h size=%0d",
                         b, o.addr, o.size, o.done1, o.busy_after, o.short_after, m_addr[exp], m_size[exp]);
                n_bad++;
            end
            m_last = exp;
        end
        bus.i_req_addr_req = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            $display("FAIL rr_release: got busy=%b want 0", bus.o_busy);
            n_bad++;
        end
    endtask

    task automatic test_random_traffic();
        obs_t o;
        int exp;
        logic [N-1:0] mask;
        for (int b = 0; b < 20; b++) begin
            for (int k = 0; k < int'(N); k++) begin
                m_addr[k] = AW'({$urandom, $urandom});
                m_size[k] = SW'($urandom_range(1, 8));
            end
            apply_reqs();
            mask = N'($urandom_range(1, (1 << N) - 1));
            exp  = model_pick(mask, m_last);
            do_burst(mask, 1'b0, $urandom_range(0, 4), int'(m_size[exp]), $urandom_range(0, 2), o);
            n_cmp++;
            if (o.timeout || o.gid != exp || o.addr !== m_addr[exp] || o.size !== m_size[exp]) begin
                $display("FAIL rand_grant[%0d]: mask=%b got id=%0d addr=%0h size=%0d want id=%0d addr=%0h size=%0d",
                         b, mask, o.gid, o.addr, o.size, exp, m_addr[exp], m_size[exp]);
                n_bad++;
            end
            n_cmp++;
            if (o.ready_bad != 0 || o.strobe_bad != 0 || o.done1 !== (N'(1) << exp)
                || o.short_after !== 1'b0) begin
                $display("FAIL rand_data[%0d]: got rdy_err=%0d strb_err=%0d done=%b short=%b want 0/0/onehot(%0d)/0",
                         b, o.ready_bad, o.strobe_bad, o.done1, o.short_after, exp);
                n_bad++;
            end
            m_last = exp;
        end
    endtask

    task automatic test_wdog();
        int exp, cyc, first;
        logic [N-1:0] done_at;
        exp = model_pick(4'b0001, m_last);
        @(negedge clk);
        bus.i_req_addr_req = 4'b0001;
        cyc = 0;
        while (bus.o_mm2s_addr_req !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        bus.i_mm2s_addr_ready = 1'b1;
        @(negedge clk);
        bus.i_mm2s_addr_ready = 1'b0;
        bus.i_req_addr_req    = '0;
        first   = 0;
        done_at = '0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (bus.o_wdog_err === 1'b1 && first == 0) begin
                first   = k;
                done_at = bus.o_req_done;
            end
            @(negedge clk);
        end
`ifdef MM2S_RD_ARB_WDOG_EN
        n_cmp++;
        if (first != int'(WD) || done_at !== (N'(1) << exp)) begin
            $display("FAIL wdog_pulse: got cycle=%0d done=%b want cycle=%0d done=onehot(%0d)",
                     first, done_at, WD, exp);
            n_bad++;
        end
        n_cmp++;
        if (bus.o_busy !== 1'b0) begin
            $display("FAIL wdog_idle: got busy=%b want 0", bus.o_busy);
            n_bad++;
        end
`else
        n_cmp++;
        if (first != 0 || bus.o_busy !== 1'b1) begin
            $display("FAIL wdog_off: got pulse cycle=%0d busy=%b want none/1", first, bus.o_busy);
            n_bad++;
        end
        bus.i_mm2s_done = 1'b1;
        #1;
        n_cmp++;
        if (bus.o_req_done !== (N'(1) << exp)) begin
            $display("FAIL wdog_off_done: got %b want onehot(%0d)", bus.o_req_done, exp);
            n_bad++;
        end
        @(negedge clk);
        bus.i_mm2s_done = 1'b0;
`endif
        m_last = exp;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int k = 0; k < int'(N); k++) begin
            m_addr[k] = '0;
            m_size[k] = '0;
        end
        bus.i_req_addr = '0;
        bus.i_req_size = '0;
        do_reset();
        #1;
        test_reset();
        test_single();
        test_foreign_id();
        test_short();
        test_reset_mid_data();
        test_round_robin();
        test_random_traffic();
        test_wdog();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
